// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light sequencer: state
// encoding, lamp patterns, reprogram selector codes and default phase times.
package tl_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    ST_MG   = 3'd0,
    ST_MY   = 3'd1,
    ST_WALK = 3'd2,
    ST_SG   = 3'd3,
    ST_SY   = 3'd4
  } tl_state_e;

  // Lamp patterns, {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Time_Param_Selector codes
  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Default phase times in Tick units, and parameter width
  localparam int T_BASE_DEF_C = 6;
  localparam int T_EXT_DEF_C  = 3;
  localparam int T_YEL_DEF_C  = 2;
  localparam int TW_C         = 4;

  // Full lamp picture for one phase
  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
  } tl_lamps_t;

  // Moore lamp decode: crossing roads never show red and green together
  function automatic tl_lamps_t lamps_for(input tl_state_e s);
    tl_lamps_t l;
    l = '{main_l: LAMP_G, side_l: LAMP_R, walk_l: 1'b0};
    case (s)
      ST_MG:   l = '{main_l: LAMP_G, side_l: LAMP_R, walk_l: 1'b0};
      ST_MY:   l = '{main_l: LAMP_Y, side_l: LAMP_R, walk_l: 1'b0};
      ST_WALK: l = '{main_l: LAMP_R, side_l: LAMP_R, walk_l: 1'b1};
      ST_SG:   l = '{main_l: LAMP_R, side_l: LAMP_G, walk_l: 1'b0};
      ST_SY:   l = '{main_l: LAMP_R, side_l: LAMP_Y, walk_l: 1'b0};
      default: l = '{main_l: LAMP_G, side_l: LAMP_R, walk_l: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase down-counter. A load always wins; otherwise it counts down one per
// tick. Expiry is flagged combinationally when the count is 1 and a tick is
// present, so a phase loaded with N ends on exactly the N-th tick.
module tl_timer #(
  parameter int              CW      = 5,
  parameter logic [CW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q;

  // Count register: reset value, then load-over-decrement priority
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Expiry strobe aligned with the tick that consumes the last unit
  always_comb begin
    expire_o = tick && (cnt_q == CW'(1));
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main traffic-light sequencer: MG -> MY -> [WALK] -> SG -> SY -> MG, with
// sensor-driven shortening/extension, a latched walk request and run-time
// reprogramming of the three phase times.
// Optional build macro TL_FLASH_MODE_EN adds the Flash_Mode input (flashing
// yellow/red with the sequencer frozen).
module traffic_light_fsm
  import tl_pkg::*;
#(
  parameter int T_BASE_DEF = T_BASE_DEF_C,
  parameter int T_EXT_DEF  = T_EXT_DEF_C,
  parameter int T_YEL_DEF  = T_YEL_DEF_C,
  parameter int TW         = TW_C
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Tick,
  input  logic          Sensor_Sync,
  input  logic          WR_Sync,
  input  logic          Prog_Sync,
`ifdef TL_FLASH_MODE_EN
  input  logic          Flash_Mode,
`endif
  input  logic [1:0]    Time_Param_Selector,
  input  logic [TW-1:0] Time_Value,
  output logic [2:0]    Main_Light,
  output logic [2:0]    Side_Light,
  output logic          Walk_Lamp
);

  tl_state_e     state_q, state_d;
  logic          half_q, half_d;     // MG second half in progress
  logic          ext_q, ext_d;       // SG extension in progress
  logic          walk_q, walk_d;     // pending pedestrian request
  logic [TW-1:0] t_base_q, t_base_d;
  logic [TW-1:0] t_ext_q, t_ext_d;
  logic [TW-1:0] t_yel_q, t_yel_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    side_q, side_d;
  logic          walk_lamp_q, walk_lamp_d;
  tl_lamps_t     lamps;

  logic          hold;               // sequencer and timer frozen
  logic          restart;            // leaving flash: restart at MG
  logic          tmr_tick;
  logic          tmr_load;
  logic [TW:0]   tmr_val;
  logic          tmr_expire;
  logic          enter_walk;

`ifdef TL_FLASH_MODE_EN
  logic          flash_act_q;
  logic          ph_q, ph_d;         // 0 = lamps lit, 1 = lamps dark

  assign hold    = Flash_Mode;
  assign restart = flash_act_q & ~Flash_Mode;
`else
  assign hold    = 1'b0;
  assign restart = 1'b0;
`endif

  assign tmr_tick = Tick & ~hold;

  tl_timer #(
    .CW      (TW + 1),
    .RST_VAL ((TW + 1)'(T_BASE_DEF))
  ) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .tick     (tmr_tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire_o (tmr_expire)
  );

  // Parameter update: a zero value or the "none" selector leaves all times alone
  always_comb begin
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    if (Prog_Sync && (Time_Value != '0)) begin
      case (Time_Param_Selector)
        SEL_BASE: t_base_d = Time_Value;
        SEL_EXT:  t_ext_d  = Time_Value;
        SEL_YEL:  t_yel_d  = Time_Value;
        default:  ;
      endcase
    end
  end

  // Next-state: freeze > reprogram restart > flash-release restart > timer expiry
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    ext_d      = ext_q;
    tmr_load   = 1'b0;
    tmr_val    = {1'b0, t_base_q};
    enter_walk = 1'b0;
    if (hold) begin
      state_d = state_q;
    end else if (Prog_Sync) begin
      // Restart with the freshly written base time
      state_d  = ST_MG;
      half_d   = 1'b0;
      ext_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = {1'b0, t_base_d};
    end else if (restart) begin
      state_d  = ST_MG;
      half_d   = 1'b0;
      ext_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = {1'b0, t_base_q};
    end else if (tmr_expire) begin
      tmr_load = 1'b1;
      case (state_q)
        ST_MG: begin
          if (half_q || Sensor_Sync) begin
            state_d = ST_MY;
            half_d  = 1'b0;
            tmr_val = {1'b0, t_yel_q};
          end else begin
            half_d  = 1'b1;
            tmr_val = {1'b0, t_base_q};
          end
        end
        ST_MY: begin
          if (walk_q) begin
            state_d    = ST_WALK;
            enter_walk = 1'b1;
            tmr_val    = {1'b0, t_ext_q};
          end else begin
            state_d = ST_SG;
            ext_d   = 1'b0;
            tmr_val = {1'b0, t_base_q};
          end
        end
        ST_WALK: begin
          state_d = ST_SG;
          ext_d   = 1'b0;
          tmr_val = {1'b0, t_base_q};
        end
        ST_SG: begin
          if (!ext_q && Sensor_Sync) begin
            ext_d   = 1'b1;
            tmr_val = {1'b0, t_ext_q};
          end else begin
            state_d = ST_SY;
            ext_d   = 1'b0;
            tmr_val = {1'b0, t_yel_q};
          end
        end
        ST_SY: begin
          state_d = ST_MG;
          half_d  = 1'b0;
          tmr_val = {1'b0, t_base_q};
        end
        default: begin
          state_d = ST_MG;
          half_d  = 1'b0;
          ext_d   = 1'b0;
          tmr_val = {1'b0, t_base_q};
        end
      endcase
    end
  end

  // Walk latch: entry into WALK consumes the request, a new request re-arms it
  always_comb begin
    walk_d = (enter_walk ? 1'b0 : walk_q) | WR_Sync;
  end

  // Output decode from the next state so the lamp registers track state_q
  always_comb begin
    lamps       = lamps_for(state_d);
    main_d      = lamps.main_l;
    side_d      = lamps.side_l;
    walk_lamp_d = lamps.walk_l;
`ifdef TL_FLASH_MODE_EN
    // First flash cycle is lit; each subsequent tick toggles the phase
    ph_d = Flash_Mode & (ph_q ^ (Tick & flash_act_q));
    if (Flash_Mode) begin
      main_d      = ph_d ? LAMP_OFF : LAMP_Y;
      side_d      = ph_d ? LAMP_OFF : LAMP_R;
      walk_lamp_d = 1'b0;
    end
`endif
  end

  // State, parameter, latch and registered-lamp update
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_MG;
      half_q      <= 1'b0;
      ext_q       <= 1'b0;
      walk_q      <= 1'b0;
      t_base_q    <= TW'(T_BASE_DEF);
      t_ext_q     <= TW'(T_EXT_DEF);
      t_yel_q     <= TW'(T_YEL_DEF);
      main_q      <= LAMP_G;
      side_q      <= LAMP_R;
      walk_lamp_q <= 1'b0;
`ifdef TL_FLASH_MODE_EN
      flash_act_q <= 1'b0;
      ph_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      ext_q       <= ext_d;
      walk_q      <= walk_d;
      t_base_q    <= t_base_d;
      t_ext_q     <= t_ext_d;
      t_yel_q     <= t_yel_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_lamp_q <= walk_lamp_d;
`ifdef TL_FLASH_MODE_EN
      flash_act_q <= Flash_Mode;
      ph_q        <= ph_d;
`endif
    end
  end

  assign Main_Light = main_q;
  assign Side_Light = side_q;
  assign Walk_Lamp  = walk_lamp_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: Tick every 4 clocks, lamps checked
// between edges against hand-computed phase lengths.
module tb_traffic_light_fsm;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic       Sensor = 1'b0;
  logic       WR = 1'b0;
  logic       Prog = 1'b0;
  logic [1:0] Sel = 2'b11;
  logic [3:0] TV = 4'd0;
  logic [2:0] Main, Side;
  logic       Walk;
`ifdef TL_FLASH_MODE_EN
  logic       Flash = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk                 (clk),
    .Reset               (Reset),
    .Tick                (Tick),
    .Sensor_Sync         (Sensor),
    .WR_Sync             (WR),
    .Prog_Sync           (Prog),
`ifdef TL_FLASH_MODE_EN
    .Flash_Mode          (Flash),
`endif
    .Time_Param_Selector (Sel),
    .Time_Value          (TV),
    .Main_Light          (Main),
    .Side_Light          (Side),
    .Walk_Lamp           (Walk)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n Tick periods: Tick high for one clock, then three idle clocks
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b1;
      cyc();
      Tick = 1'b0;
      repeat (3) cyc();
    end
  endtask

  task automatic check(input string tag, input logic [2:0] m, input logic [2:0] s, input logic w);
    n_vec++;
    assert ({Main, Side, Walk} === {m, s, w}) else begin
      n_err++;
      $error("FAIL %s: got main=%b side=%b walk=%b, want main=%b side=%b walk=%b",
             tag, Main, Side, Walk, m, s, w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    check("reset", G, R, 1'b0);
    Reset = 1'b0;

    // Plain cycle: MG 12, MY 2, SG 6, SY 2
    tick_n(11); check("mg_11", G, R, 1'b0);
    tick_n(1);  check("my_enter", Y, R, 1'b0);
    tick_n(1);  check("my_1", Y, R, 1'b0);
    tick_n(1);  check("sg_enter", R, G, 1'b0);
    tick_n(5);  check("sg_5", R, G, 1'b0);
    tick_n(1);  check("sy_enter", R, Y, 1'b0);
    tick_n(1);  check("sy_1", R, Y, 1'b0);
    tick_n(1);  check("mg_again", G, R, 1'b0);

    // Sensor held: MG shortened to 6, SG extended to 9
    Sensor = 1'b1;
    tick_n(5);  check("sens_mg_5", G, R, 1'b0);
    tick_n(1);  check("sens_my", Y, R, 1'b0);
    tick_n(2);  check("sens_sg", R, G, 1'b0);
    tick_n(8);  check("sens_sg_8", R, G, 1'b0);
    tick_n(1);  check("sens_sy", R, Y, 1'b0);
    tick_n(2);  check("sens_mg", G, R, 1'b0);
    Sensor = 1'b0;

    // One-cycle walk request during MG
    WR = 1'b1; cyc(); WR = 1'b0;
    tick_n(12); check("wr_my", Y, R, 1'b0);
    tick_n(2);  check("walk_enter", R, R, 1'b1);
    tick_n(2);  check("walk_2", R, R, 1'b1);
    tick_n(1);  check("walk_sg", R, G, 1'b0);
    tick_n(6);  check("walk_sy", R, Y, 1'b0);
    tick_n(2);  check("walk_mg", G, R, 1'b0);
    // Second pass without request skips WALK
    tick_n(12); check("nowr_my", Y, R, 1'b0);
    tick_n(2);  check("nowr_sg", R, G, 1'b0);

    // Reprogram yellow with 0 mid-SG: ignored, restart at MG
    tick_n(3);
    Prog = 1'b1; Sel = 2'b10; TV = 4'd0; cyc(); Prog = 1'b0;
    check("prog0_mg", G, R, 1'b0);
    tick_n(12); check("prog0_my", Y, R, 1'b0);
    tick_n(1);  check("prog0_my_1", Y, R, 1'b0);
    tick_n(1);  check("prog0_sg", R, G, 1'b0);

    // Reprogram yellow to 5 mid-SG
    tick_n(3);
    Prog = 1'b1; Sel = 2'b10; TV = 4'd5; cyc(); Prog = 1'b0;
    check("prog5_mg", G, R, 1'b0);
    tick_n(12); check("prog5_my", Y, R, 1'b0);
    tick_n(4);  check("prog5_my_4", Y, R, 1'b0);
    tick_n(1);  check("prog5_sg", R, G, 1'b0);

    // Prog held with selector 11 pins MG; base stays 6
    Prog = 1'b1; Sel = 2'b11; TV = 4'd7;
    tick_n(3);  check("prog_held", G, R, 1'b0);
    Prog = 1'b0; cyc();
    tick_n(11); check("held_mg_11", G, R, 1'b0);
    tick_n(1);  check("held_my", Y, R, 1'b0);

    // Walk request, then Reset together with Prog mid-WALK
    WR = 1'b1; cyc(); WR = 1'b0;
    tick_n(5);  check("rst_walk", R, R, 1'b1);
    tick_n(1);
    Reset = 1'b1; Prog = 1'b1; Sel = 2'b00; TV = 4'd9; cyc();
    Reset = 1'b0; Prog = 1'b0;
    check("rst_mg", G, R, 1'b0);
    tick_n(12); check("rst_my", Y, R, 1'b0);
    tick_n(1);  check("rst_my_1", Y, R, 1'b0);
    tick_n(1);  check("rst_sg", R, G, 1'b0);

`ifdef TL_FLASH_MODE_EN
    // Flash for 4 Ticks, then restart at MG with a 6-Tick first half
    Flash = 1'b1; cyc();
    check("flash_0", Y, R, 1'b0);
    tick_n(1);  check("flash_1", O, O, 1'b0);
    tick_n(1);  check("flash_2", Y, R, 1'b0);
    tick_n(1);  check("flash_3", O, O, 1'b0);
    Flash = 1'b0; Sensor = 1'b1; cyc();
    check("flash_rel", G, R, 1'b0);
    tick_n(5);  check("flash_mg_5", G, R, 1'b0);
    tick_n(1);  check("flash_my", Y, R, 1'b0);
    Sensor = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main traffic-light sequencer. Consumes the already-synchronized Sensor_Sync, WR_Sync and Prog_Sync strobes from the Synchronizer.
- Drives the main-street and side-street lamps and the walk lamp.
- Phase durations come from three programmable time parameters, counted in Tick units. Tick is a 1-cycle enable from the system 1 Hz divider.
- Sits between the Synchronizer and the lamp output drivers.

Parameters:
- T_BASE_DEF, 6, reset value of the base time (ticks).
- T_EXT_DEF, 3, reset value of the extended/walk time (ticks).
- T_YEL_DEF, 2, reset value of the yellow time (ticks).
- TW, 4, width of each time parameter and of Time_Value.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  one-cycle timing enable; the FSM timer advances only on Tick.
- Sensor_Sync  in  1  side-street vehicle present (level).
- WR_Sync  in  1  walk request (level or pulse).
- Prog_Sync  in  1  reprogram strobe.
- Time_Param_Selector  in  2  00 = base, 01 = ext, 10 = yellow, 11 = none.
- Time_Value  in  TW  value to program.
- Main_Light  out  3  {R,Y,G}, one-hot.
- Side_Light  out  3  {R,Y,G}, one-hot.
- Walk_Lamp  out  1  pedestrian walk lamp.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port Reset.
- Reset (highest priority):
  - State = MG. Main_Light = 001, Side_Light = 100, Walk_Lamp = 0.
  - Params are set to their *_DEF values and the walk latch is cleared.
  - Timer = T_BASE, with the MG second-half flag clear.
- States, with lamps (Main/Side/Walk) and duration:
  - MG: 001/100/0, T_BASE per half.
  - MY: 010/100/0, T_YEL.
  - WALK: 100/100/1, T_EXT.
  - SG: 100/001/0, T_BASE, plus T_EXT if extended.
  - SY: 100/010/0, T_YEL.
- Timer:
  - Down-counter, width TW+1.
  - Loaded with the new state's duration in the same cycle as the transition.
  - Decrements only on Tick.
  - When the counter equals 1 and Tick is high, the state ends on that clock edge. A phase of N therefore lasts exactly N Ticks.
- Transitions:
  - MG, first half ends: if Sensor_Sync = 1, go to MY (main green is shortened to T_BASE). Otherwise set the second-half flag and reload T_BASE.
  - MG, second half ends: go to MY (total 2*T_BASE).
  - MY ends: go to WALK if the walk latch is set, else go to SG.
  - WALK ends: go to SG.
  - SG, base ends: if Sensor_Sync = 1, reload T_EXT once (extension flag). Otherwise go to SY.
  - SG, extension ends: go to SY.
  - SY ends: go to MG (first half).
- Walk latch:
  - Set by WR_Sync = 1 in any state.
  - Cleared on the cycle of entry into WALK.
  - A WR_Sync asserted during WALK re-sets the latch; it is served in the next cycle.
- Reprogram (Prog_Sync = 1, no Reset):
  - If selector ≠ 11 and Time_Value ≠ 0, write Time_Value into the selected parameter. A value of 0 is ignored and the previous value is kept.
  - Regardless of the write, the FSM restarts at MG first half and the timer loads the new T_BASE on the following cycle.
  - Lamps show MG from the next cycle.
  - Prog_Sync held high keeps the FSM pinned in MG.
- Simultaneous events:
  - Reset overrides Prog_Sync.
  - Prog_Sync overrides a Tick-driven transition.
  - WR_Sync during Prog_Sync still sets the latch.
- Outputs are registered, Moore-style.
- Red and green are never both asserted on crossing roads.

Optional Feature:
- Macro: TL_FLASH_MODE_EN.
- When defined, adds input Flash_Mode (1 bit).
  - While Flash_Mode = 1: Main_Light alternates 010/000 and Side_Light alternates 100/000, toggling on each Tick. Walk_Lamp = 0, and the FSM and timer are held.
  - On release, the FSM restarts at MG with a T_BASE load.
  - Reset clears the flash phase.
- When not defined: the port is absent and there is no flash logic.

Decomposition:
- Package tl_pkg:
  - State enum (MG, MY, WALK, SG, SY).
  - Lamp encodings (LAMP_R = 100, LAMP_Y = 010, LAMP_G = 001, LAMP_OFF).
  - Selector codes (SEL_BASE, SEL_EXT, SEL_YEL).
  - Default time constants.
- Sub-module tl_timer: load/decrement/expire down-counter with Tick enable. Instantiated once.

Test Plan:
- Reset, then Tick every 4 clk, Sensor = 0, WR = 0: MG for 12 Ticks, MY 2, SG 6, SY 2, then MG again.
- Sensor_Sync = 1 throughout: MG lasts 6 Ticks, SG lasts 6 + 3 = 9 Ticks.
- 1-cycle WR_Sync pulse during MG: after MY, WALK with Walk_Lamp = 1 and both roads red for 3 Ticks, then SG. A second pass without a request skips WALK.
- Prog_Sync with selector 10, value 5, mid-SG: next cycle Main = 001; subsequent MY lasts 5 Ticks. With value 0: T_YEL stays 2.
- Reset asserted mid-WALK together with Prog_Sync: next cycle Main = 001, Side = 100, Walk = 0, defaults restored (MY = 2 Ticks).
- TL_FLASH_MODE_EN build, Flash_Mode = 1 for 4 Ticks: Main 010, 000, 010, 000 and Side 100, 000, 100, 000. On release the FSM restarts at MG with a 6-Tick first half.
